// File: rtl/register_file_responder_pkg.sv
// Shared CPU package for the register-value lookup responder.
// Holds sizing constants and the per-register scoreboard entry layout.
package register_file_responder_pkg;

    localparam int XLEN    = 32;
    localparam int REG_CNT = 32;
    localparam int TAG_W   = 6;

    typedef struct packed {
        logic [XLEN-1:0]  value;
        logic             busy;
        logic [TAG_W-1:0] tag;
        logic             spec;
        logic             shadow_busy;
        logic [TAG_W-1:0] shadow_tag;
    } reg_entry_t;

endpackage

// File: rtl/register_file_responder_reg_lookup_bypass.sv
// One source-operand lookup: stored entry, then commit forwarding,
// then intra-bundle rename forwarding, with x0 forced to a ready zero.
module reg_lookup_bypass
    import register_file_responder_pkg::*;
(
    input  logic [4:0]       src_idx,
    input  logic             bundle_check,
    input  logic             ren_en,
    input  logic [4:0]       ren_reg,
    input  logic [TAG_W-1:0] ren_tag,
    input  logic [XLEN-1:0]  entry_value,
    input  logic             entry_busy,
    input  logic [TAG_W-1:0] entry_tag,
    input  logic             cmt_en   [2],
    input  logic [4:0]       cmt_reg  [2],
    input  logic [TAG_W-1:0] cmt_tag  [2],
    input  logic [XLEN-1:0]  cmt_data [2],
    output logic [XLEN-1:0]  data,
    output logic             valid
);

    // Later assignments override earlier ones, so priority rises down the block.
    always_comb begin
        valid = !entry_busy;
        data  = entry_busy ? XLEN'(entry_tag) : entry_value;
        for (int j = 0; j < 2; j++) begin
            if (cmt_en[j] && (cmt_reg[j] == src_idx) && (entry_tag == cmt_tag[j])) begin
                valid = 1'b1;
                data  = cmt_data[j];
            end
        end
        if (bundle_check && ren_en && (ren_reg == src_idx)) begin
            valid = 1'b0;
            data  = XLEN'(ren_tag);
        end
        if (src_idx == 5'd0) begin
            valid = 1'b1;
            data  = '0;
        end
    end

endmodule

// File: rtl/register_file_responder.sv
// Two-wide register file with busy/tag scoreboard and speculative shadow state.
// Optional debug tap of x11 enabled by defining DEBUG_REG_TAP_EN.
module register_file_responder
    import register_file_responder_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             delete_tagged,
    input  logic             clear_tags,
    input  logic [5:0]       src_1    [2],
    input  logic [5:0]       src_2    [2],
    output logic [XLEN-1:0]  data_1   [2],
    output logic [XLEN-1:0]  data_2   [2],
    output logic             valid_1  [2],
    output logic             valid_2  [2],
    input  logic             ren_en   [2],
    input  logic [4:0]       ren_reg  [2],
    input  logic [TAG_W-1:0] ren_tag  [2],
    input  logic             ren_spec [2],
    input  logic             cmt_en   [2],
    input  logic [4:0]       cmt_reg  [2],
    input  logic [TAG_W-1:0] cmt_tag  [2],
    input  logic [XLEN-1:0]  cmt_data [2]
`ifdef DEBUG_REG_TAP_EN
    ,
    output logic [XLEN-1:0]  reg_11_value
`endif
);

    reg_entry_t regs [REG_CNT];
    reg_entry_t nxt  [REG_CNT];

    always_comb begin
        logic renamed;
        logic was_spec;
        for (int r = 0; r < REG_CNT; r++) begin
            nxt[r]   = regs[r];
            renamed  = 1'b0;
            was_spec = 1'b0;
            if (r == 0) begin
                nxt[r] = '0;
            end else begin
                if (delete_tagged && regs[r].spec) begin
                    nxt[r].busy = regs[r].shadow_busy;
                    nxt[r].tag  = regs[r].shadow_tag;
                    nxt[r].spec = 1'b0;
                end else if (clear_tags) begin
                    nxt[r].spec = 1'b0;
                end
                was_spec = nxt[r].spec;
                // A flush drops speculative renames but lets ordinary ones through.
                for (int j = 0; j < 2; j++) begin
                    if (ren_en[j] && (ren_reg[j] == 5'(r)) && !(delete_tagged && ren_spec[j]))
                        renamed = 1'b1;
                end
                for (int j = 0; j < 2; j++) begin
                    if (cmt_en[j] && (cmt_reg[j] == 5'(r))) begin
                        nxt[r].value = cmt_data[j];
                        if (nxt[r].busy && (nxt[r].tag == cmt_tag[j]) && !renamed)
                            nxt[r].busy = 1'b0;
                    end
                end
                for (int j = 0; j < 2; j++) begin
                    if (ren_en[j] && (ren_reg[j] == 5'(r)) && !(delete_tagged && ren_spec[j])) begin
                        nxt[r].busy = 1'b1;
                        nxt[r].tag  = ren_tag[j];
                        nxt[r].spec = ren_spec[j];
                        if (ren_spec[j] && !was_spec) begin
                            nxt[r].shadow_busy = regs[r].busy;
                            nxt[r].shadow_tag  = regs[r].tag;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            regs <= '{default: '0};
        else
            regs <= nxt;
    end

    for (genvar i = 0; i < 2; i++) begin : g_lookup
        // Only the second instruction can depend on the first one's destination.
        reg_lookup_bypass u_src_1 (
            .src_idx      (src_1[i][4:0]),
            .bundle_check (i == 1),
            .ren_en       (ren_en[0]),
            .ren_reg      (ren_reg[0]),
            .ren_tag      (ren_tag[0]),
            .entry_value  (regs[src_1[i][4:0]].value),
            .entry_busy   (regs[src_1[i][4:0]].busy),
            .entry_tag    (regs[src_1[i][4:0]].tag),
            .cmt_en       (cmt_en),
            .cmt_reg      (cmt_reg),
            .cmt_tag      (cmt_tag),
            .cmt_data     (cmt_data),
            .data         (data_1[i]),
            .valid        (valid_1[i])
        );
        reg_lookup_bypass u_src_2 (
            .src_idx      (src_2[i][4:0]),
            .bundle_check (i == 1),
            .ren_en       (ren_en[0]),
            .ren_reg      (ren_reg[0]),
            .ren_tag      (ren_tag[0]),
            .entry_value  (regs[src_2[i][4:0]].value),
            .entry_busy   (regs[src_2[i][4:0]].busy),
            .entry_tag    (regs[src_2[i][4:0]].tag),
            .cmt_en       (cmt_en),
            .cmt_reg      (cmt_reg),
            .cmt_tag      (cmt_tag),
            .cmt_data     (cmt_data),
            .data         (data_2[i]),
            .valid        (valid_2[i])
        );
    end

`ifdef DEBUG_REG_TAP_EN
    assign reg_11_value = regs[11].value;
`endif

endmodule

// File: tb/tb_register_file_responder.sv
// Directed self-checking bench for register_file_responder.
// Covers reset, rename/commit forwarding, bundle hazards, x0, speculation, async reset.
module tb_register_file_responder;

    logic        clk;
    logic        reset;
    logic        delete_tagged;
    logic        clear_tags;
    logic [5:0]  src_1    [2];
    logic [5:0]  src_2    [2];
    logic [31:0] data_1   [2];
    logic [31:0] data_2   [2];
    logic        valid_1  [2];
    logic        valid_2  [2];
    logic        ren_en   [2];
    logic [4:0]  ren_reg  [2];
    logic [5:0]  ren_tag  [2];
    logic        ren_spec [2];
    logic        cmt_en   [2];
    logic [4:0]  cmt_reg  [2];
    logic [5:0]  cmt_tag  [2];
    logic [31:0] cmt_data [2];

    int passCount = 0;
    int totalCount = 0;

    register_file_responder dut (
        .clk           (clk),
        .reset         (reset),
        .delete_tagged (delete_tagged),
        .clear_tags    (clear_tags),
        .src_1         (src_1),
        .src_2         (src_2),
        .data_1        (data_1),
        .data_2        (data_2),
        .valid_1       (valid_1),
        .valid_2       (valid_2),
        .ren_en        (ren_en),
        .ren_reg       (ren_reg),
        .ren_tag       (ren_tag),
        .ren_spec      (ren_spec),
        .cmt_en        (cmt_en),
        .cmt_reg       (cmt_reg),
        .cmt_tag       (cmt_tag),
        .cmt_data      (cmt_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
    endtask

    task automatic applyStimulus();
        for (int j = 0; j < 2; j++) begin
            ren_en[j]   = 1'b0;
            ren_reg[j]  = '0;
            ren_tag[j]  = '0;
            ren_spec[j] = 1'b0;
            cmt_en[j]   = 1'b0;
            cmt_reg[j]  = '0;
            cmt_tag[j]  = '0;
            cmt_data[j] = '0;
        end
        delete_tagged = 1'b0;
        clear_tags    = 1'b0;
    endtask

    task automatic stepIdle();
        @(posedge clk);
        #1;
        applyStimulus();
        #1;
    endtask

    task automatic doRen(input int slot, input logic [4:0] r, input logic [5:0] t, input logic s);
        ren_en[slot]   = 1'b1;
        ren_reg[slot]  = r;
        ren_tag[slot]  = t;
        ren_spec[slot] = s;
    endtask

    task automatic doCmt(input int slot, input logic [4:0] r, input logic [5:0] t, input logic [31:0] d);
        cmt_en[slot]   = 1'b1;
        cmt_reg[slot]  = r;
        cmt_tag[slot]  = t;
        cmt_data[slot] = d;
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus();
        src_1[0] = 6'd5;
        src_2[0] = 6'd7;
        src_1[1] = 6'd11;
        src_2[1] = 6'd31;
        #2;
        checkOutput("rst_v1_0", 32'(valid_1[0]), 32'd1);
        checkOutput("rst_d1_0", data_1[0], 32'd0);
        checkOutput("rst_v2_0", 32'(valid_2[0]), 32'd1);
        checkOutput("rst_d2_0", data_2[0], 32'd0);
        checkOutput("rst_v1_1", 32'(valid_1[1]), 32'd1);
        checkOutput("rst_d1_1", data_1[1], 32'd0);
        checkOutput("rst_v2_1", 32'(valid_2[1]), 32'd1);
        checkOutput("rst_d2_1", data_2[1], 32'd0);
        @(negedge clk);
        reset = 1'b1;
        stepIdle();

        // Test 1: rename x5 tag 9 becomes visible next cycle
        doRen(0, 5'd5, 6'd9, 1'b0);
        stepIdle();
        src_1[0] = 6'd5;
        #1;
        checkOutput("t1_valid", 32'(valid_1[0]), 32'd0);
        checkOutput("t1_data", data_1[0], 32'd9);

        // Test 2: matching commit forwards same cycle, then frees the register
        doCmt(0, 5'd5, 6'd9, 32'hDEAD);
        #1;
        checkOutput("t2_byp_valid", 32'(valid_1[0]), 32'd1);
        checkOutput("t2_byp_data", data_1[0], 32'hDEAD);
        stepIdle();
        checkOutput("t2_post_valid", 32'(valid_1[0]), 32'd1);
        checkOutput("t2_post_data", data_1[0], 32'hDEAD);

        // Test 3: stale commit does not free a re-renamed register
        doRen(0, 5'd5, 6'd9, 1'b0);
        stepIdle();
        doRen(1, 5'd5, 6'd12, 1'b0);
        stepIdle();
        doCmt(1, 5'd5, 6'd9, 32'd7);
        #1;
        checkOutput("t3_same_valid", 32'(valid_1[0]), 32'd0);
        checkOutput("t3_same_data", data_1[0], 32'd12);
        stepIdle();
        checkOutput("t3_post_valid", 32'(valid_1[0]), 32'd0);
        checkOutput("t3_post_data", data_1[0], 32'd12);
        doCmt(0, 5'd5, 6'd12, 32'h55);
        stepIdle();
        checkOutput("t3_free_data", data_1[0], 32'h55);

        // Test 4: intra-bundle hazard and x0
        doRen(0, 5'd3, 6'd4, 1'b0);
        src_1[0] = 6'd3;
        src_1[1] = 6'd3;
        src_2[0] = 6'd0;
        src_2[1] = 6'd0;
        #1;
        checkOutput("t4_i1_valid", 32'(valid_1[1]), 32'd0);
        checkOutput("t4_i1_data", data_1[1], 32'd4);
        checkOutput("t4_i0_valid", 32'(valid_1[0]), 32'd1);
        checkOutput("t4_i0_data", data_1[0], 32'd0);
        checkOutput("t4_x0_v0", 32'(valid_2[0]), 32'd1);
        checkOutput("t4_x0_v1", 32'(valid_2[1]), 32'd1);
        stepIdle();
        doRen(0, 5'd0, 6'd5, 1'b0);
        doCmt(1, 5'd0, 6'd5, 32'h99);
        src_1[1] = 6'd0;
        #1;
        checkOutput("t4_x0_bundle_v", 32'(valid_1[1]), 32'd1);
        checkOutput("t4_x0_bundle_d", data_1[1], 32'd0);
        stepIdle();
        checkOutput("t4_x0_after_v", 32'(valid_1[1]), 32'd1);
        checkOutput("t4_x0_after_d", data_1[1], 32'd0);
        // bit 5 of the source index is ignored: 6'h25 reads x5
        src_2[1] = 6'h25;
        #1;
        checkOutput("t4_bit5_data", data_2[1], 32'h55);

        // Test 5: speculative rename undone by delete_tagged
        src_1[0] = 6'd6;
        doRen(0, 5'd6, 6'd2, 1'b0);
        stepIdle();
        doRen(0, 5'd6, 6'd8, 1'b1);
        stepIdle();
        checkOutput("t5_spec_data", data_1[0], 32'd8);
        delete_tagged = 1'b1;
        stepIdle();
        checkOutput("t5_del_valid", 32'(valid_1[0]), 32'd0);
        checkOutput("t5_del_data", data_1[0], 32'd2);
        doRen(0, 5'd6, 6'd8, 1'b1);
        stepIdle();
        clear_tags = 1'b1;
        stepIdle();
        delete_tagged = 1'b1;
        stepIdle();
        checkOutput("t5_clr_valid", 32'(valid_1[0]), 32'd0);
        checkOutput("t5_clr_data", data_1[0], 32'd8);

        // delete drops a same-cycle speculative rename, keeps a normal one
        src_1[0] = 6'd9;
        src_2[0] = 6'd10;
        delete_tagged = 1'b1;
        doRen(0, 5'd9, 6'd3, 1'b1);
        doRen(1, 5'd10, 6'd13, 1'b0);
        stepIdle();
        checkOutput("t5_drop_valid", 32'(valid_1[0]), 32'd1);
        checkOutput("t5_keep_data", data_2[0], 32'd13);

        // both slots renaming the same register: slot 1 wins
        src_1[0] = 6'd12;
        doRen(0, 5'd12, 6'd1, 1'b0);
        doRen(1, 5'd12, 6'd2, 1'b0);
        stepIdle();
        checkOutput("t5_dual_ren", data_1[0], 32'd2);
        // both slots committing the same register: slot 1 value wins
        doCmt(0, 5'd12, 6'd2, 32'hAAAA);
        doCmt(1, 5'd12, 6'd2, 32'hBBBB);
        stepIdle();
        checkOutput("t5_dual_cmt", data_1[0], 32'hBBBB);

        // Test 6: asynchronous reset with x7 busy
        src_1[0] = 6'd7;
        doRen(0, 5'd7, 6'd5, 1'b0);
        stepIdle();
        checkOutput("t6_busy_valid", 32'(valid_1[0]), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("t6_rst_valid", 32'(valid_1[0]), 32'd1);
        checkOutput("t6_rst_data", data_1[0], 32'd0);
        @(negedge clk);
        reset = 1'b1;
        stepIdle();

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
